demux_stream_1xn: RTL and testbench
===================================

# demux_stream_1xn

Registered, parametrised 1-to-N stream demultiplexer. It is the clocked successor of the transmission-gate 1x4 demux. It routes one input beat per cycle to one of N_OUT destinations and handles a valid/ready handshake on every port. It supports two routing modes: addressed and round-robin. It sits between a single producer and N consumer channels in the digital datapath, and replaces the unclocked demux wherever backpressure or a registered output is needed.

## Interface
- DATA_W, 8, payload width in bits (≥1)
- N_OUT, 4, number of output channels (2..16)
- SEL_W, 2, select width; must satisfy 2^SEL_W ≥ N_OUT
- MODE, 0, 0 = addressed (route by in_sel), 1 = round-robin (in_sel ignored)
- CNT_W, 8, width of drop counter
- clk  input  1  single clock, rising edge
- rst_n  input  1  synchronous, active-low reset
- in_valid  input  1  producer has a beat
- in_ready  output  1  block can accept a beat this cycle
- in_data  input  DATA_W  payload
- in_sel  input  SEL_W  destination index (MODE=0 only)
- out_valid  output  N_OUT  one-hot (or zero) valid per channel
- out_ready  input  N_OUT  per-channel consumer ready
- out_data  output  DATA_W  shared payload bus, meaningful only where out_valid bit set
- err  output  1  one-cycle pulse: an out-of-range beat was dropped
- drop_cnt  output  CNT_W  saturating count of dropped beats

## Operation
- Storage is a single output stage: a full flag, dest (SEL_W), and data (DATA_W). out_valid = full ? one-hot(dest) : 0.
- Handshakes. Input transfer: in_valid & in_ready. Output transfer: full & out_ready[dest].
- in_ready = !full | out_ready[dest]. This is a pass-through pipeline: the stage accepts a new beat in the same cycle the held beat drains.
- Destination select. MODE=0: dest_next = in_sel. MODE=1: dest_next = rr_ptr.
- Round-robin pointer. rr_ptr advances by 1 only on an input transfer in MODE=1, and wraps N_OUT-1 → 0. It does not move on stalled cycles.
- Out-of-range select. In MODE=0, in_sel ≥ N_OUT while in_valid & in_ready causes these results:
  - The beat is consumed, and the stage is not loaded.
  - err = 1 for the next cycle.
  - drop_cnt increments and saturates at 2^CNT_W−1.
  - If the stage drained in that same cycle, full falls to 0.
- Otherwise a load sets full = 1 and captures dest and data. A drain with no load clears full.
- Simultaneous drain and load are legal. The stage stays full with the new contents, and no bubble is inserted.
- out_data holds its last value when full = 0. It is not tri-stated.
- Non-selected out_valid bits are always 0. A consumer must never see two valid bits set at once.
- Reset values: full = 0 (so out_valid = 0), out_data = 0, dest = 0, rr_ptr = 0, err = 0, drop_cnt = 0. in_ready = 1 in the cycle after reset is released.
- Reset mid-operation discards the held beat without emitting it. It does not emit err.

## Timing
- Latency is 1 cycle. A beat accepted at edge k appears on out_valid/out_data after edge k and is valid for cycle k+1.
- Throughput is 1 beat per cycle while the addressed consumer holds out_ready high.
- in_ready depends combinationally on out_ready[dest]. No combinational path exists from in_valid or in_data to any output.
- err is registered and asserted exactly one cycle per dropped beat. Back-to-back drops give back-to-back pulses.
- A stalled consumer holds out_valid/out_data stable until it accepts. Other channels are blocked meanwhile (head-of-line blocking is accepted).

## Test plan
- Addressed sweep (MODE=0, N_OUT=4, all out_ready=1). Stimulus: in_data=0xA5 with in_sel 0,1,2,3 on consecutive cycles. Required: out_valid = 0001, 0010, 0100, 1000 on cycles 1–4, out_data = 0xA5 each cycle, in_ready held at 1.
- Backpressure (MODE=0). Stimulus: out_ready[2]=0, send 0x11 to sel 2, then 0x22 to sel 0. Required: out_valid=0100 holds with out_data=0x11 and in_ready=0. Raising out_ready[2] drains 0x11, loads 0x22 in the same cycle, and gives out_valid=0001 on the next cycle.
- Round-robin wrap (MODE=1, N_OUT=3). Stimulus: 7 beats 1..7 with a stall (in_valid=0) after beat 2. Required: destinations 0,1,2,0,1,2,0, with the stall not advancing the pointer.
- Out-of-range drop (MODE=0, N_OUT=3, SEL_W=2, CNT_W=2). Stimulus: in_sel=3 for 5 consecutive beats. Required: no out_valid bit ever set, err high on 5 consecutive cycles, drop_cnt = 1, 2, 3, 3, 3.
- Reset mid-stream. Stimulus: hold a beat with its consumer stalled, then assert rst_n=0 for 1 cycle. Required: after the edge, out_valid=0, out_data=0, drop_cnt=0, err=0, and the next round-robin beat goes to channel 0.

Source files
------------

// File: rtl/demux_stream_1xn.sv
// demux_stream_1xn: registered 1-to-N stream demux with addressed or round-robin routing
module demux_stream_1xn #(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 4,
  parameter int SEL_W  = 2,
  parameter int MODE   = 0,
  parameter int CNT_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [SEL_W-1:0]  in_sel_i,
  output logic [N_OUT-1:0]  out_valid_o,
  input  logic [N_OUT-1:0]  out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              err_o,
  output logic [CNT_W-1:0]  drop_cnt_o
);
  localparam int NS = 2 ** SEL_W;
  localparam logic [SEL_W:0]   N_LIM = (SEL_W + 1)'(N_OUT);
  localparam logic [SEL_W-1:0] LAST  = SEL_W'(N_OUT - 1);
  logic              full_q, full_d, err_q, err_d;
  logic [SEL_W-1:0]  dest_q, dest_d, rr_q, rr_d, sel;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NS-1:0]     rdy_ext;
  logic              drain, xfer, oor, load, drop;
  // Padding lets a SEL_W-wide index address the ready vector exactly
  assign rdy_ext    = NS'(out_ready_i);
  assign drain      = full_q & rdy_ext[dest_q];
  assign in_ready_o = !full_q | drain;
  assign xfer       = in_valid_i & in_ready_o;
  assign sel        = (MODE != 0) ? rr_q : in_sel_i;
  assign oor        = (MODE == 0) && ({1'b0, in_sel_i} >= N_LIM);
  assign load       = xfer & !oor;
  assign drop       = xfer & oor;
  always_comb begin
    full_d = load | (full_q & !drain);
    dest_d = load ? sel : dest_q;
    data_d = load ? in_data_i : data_q;
    rr_d   = (MODE != 0 && xfer) ? ((rr_q == LAST) ? '0 : rr_q + 1'b1) : rr_q;
    err_d  = drop;
    cnt_d  = (drop && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      full_q <= 1'b0;
      dest_q <= '0;
      data_q <= '0;
      rr_q   <= '0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      full_q <= full_d;
      dest_q <= dest_d;
      data_q <= data_d;
      rr_q   <= rr_d;
      err_q  <= err_d;
      cnt_q  <= cnt_d;
    end
  end
  assign out_valid_o = full_q ? (N_OUT'(1) << dest_q) : '0;
  assign out_data_o  = data_q;
  assign err_o       = err_q;
  assign drop_cnt_o  = cnt_q;
endmodule

// File: tb/tb_demux_stream_1xn.sv
// tb_demux_stream_1xn: directed checks of addressed, round-robin and drop behaviour
module tb_demux_stream_1xn;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  logic       a_iv, a_ir, a_err; logic [7:0] a_id, a_od, a_cnt; logic [1:0] a_is; logic [3:0] a_ov, a_or;
  logic       b_iv, b_ir, b_err; logic [7:0] b_id, b_od, b_cnt; logic [1:0] b_is; logic [2:0] b_ov, b_or;
  logic       c_iv, c_ir, c_err; logic [7:0] c_id, c_od; logic [1:0] c_cnt, c_is; logic [2:0] c_ov, c_or;
  demux_stream_1xn #(.DATA_W(8), .N_OUT(4), .SEL_W(2), .MODE(0), .CNT_W(8)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(a_iv), .in_ready_o(a_ir), .in_data_i(a_id), .in_sel_i(a_is),
    .out_valid_o(a_ov), .out_ready_i(a_or), .out_data_o(a_od), .err_o(a_err), .drop_cnt_o(a_cnt));
  demux_stream_1xn #(.DATA_W(8), .N_OUT(3), .SEL_W(2), .MODE(1), .CNT_W(8)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(b_iv), .in_ready_o(b_ir), .in_data_i(b_id), .in_sel_i(b_is),
    .out_valid_o(b_ov), .out_ready_i(b_or), .out_data_o(b_od), .err_o(b_err), .drop_cnt_o(b_cnt));
  demux_stream_1xn #(.DATA_W(8), .N_OUT(3), .SEL_W(2), .MODE(0), .CNT_W(2)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(c_iv), .in_ready_o(c_ir), .in_data_i(c_id), .in_sel_i(c_is),
    .out_valid_o(c_ov), .out_ready_i(c_or), .out_data_o(c_od), .err_o(c_err), .drop_cnt_o(c_cnt));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst_n = 0;
    a_iv = 0; a_id = 0; a_is = 0; a_or = 4'hF;
    b_iv = 0; b_id = 0; b_is = 0; b_or = 3'h7;
    c_iv = 0; c_id = 0; c_is = 0; c_or = 3'h7;
    tick(); tick();
    rst_n = 1;
    #1;
    n_chk++; if (a_ov !== 4'b0 || b_ov !== 3'b0 || c_ov !== 3'b0) begin n_fail++; $display("FAIL reset_valid a=%b b=%b c=%b want 0", a_ov, b_ov, c_ov); end
    n_chk++; if (a_od !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", a_od); end
    n_chk++; if (a_err !== 1'b0 || a_cnt !== 8'h00) begin n_fail++; $display("FAIL reset_err err=%b cnt=%0d want 0/0", a_err, a_cnt); end
    n_chk++; if (a_ir !== 1'b1 || b_ir !== 1'b1) begin n_fail++; $display("FAIL reset_ready a=%b b=%b want 1", a_ir, b_ir); end
  endtask
  task automatic test_addressed_sweep();
    for (int i = 0; i < 4; i++) begin
      a_iv = 1; a_id = 8'hA5; a_is = 2'(i);
      #1;
      n_chk++; if (a_ir !== 1'b1) begin n_fail++; $display("FAIL sweep_ready[%0d] got %b want 1", i, a_ir); end
      tick();
      n_chk++; if (a_ov !== (4'b1 << i)) begin n_fail++; $display("FAIL sweep_valid[%0d] got %b want %b", i, a_ov, 4'b1 << i); end
      n_chk++; if (a_od !== 8'hA5) begin n_fail++; $display("FAIL sweep_data[%0d] got %h want a5", i, a_od); end
    end
    a_iv = 0;
    tick();
    n_chk++; if (a_ov !== 4'b0) begin n_fail++; $display("FAIL sweep_drain got %b want 0000", a_ov); end
  endtask
  task automatic test_backpressure();
    a_or = 4'b1011;
    a_iv = 1; a_id = 8'h11; a_is = 2;
    tick();
    a_id = 8'h22; a_is = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_chk++; if (a_ir !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d] got %b want 0", i, a_ir); end
      n_chk++; if (a_ov !== 4'b0100 || a_od !== 8'h11) begin n_fail++; $display("FAIL bp_hold[%0d] got %b/%h want 0100/11", i, a_ov, a_od); end
      tick();
    end
    a_or = 4'hF;
    #1;
    n_chk++; if (a_ir !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b want 1", a_ir); end
    tick();
    a_iv = 0;
    n_chk++; if (a_ov !== 4'b0001 || a_od !== 8'h22) begin n_fail++; $display("FAIL bp_reload got %b/%h want 0001/22", a_ov, a_od); end
    tick();
    n_chk++; if (a_ov !== 4'b0) begin n_fail++; $display("FAIL bp_empty got %b want 0000", a_ov); end
  endtask
  task automatic test_round_robin();
    logic       vld[8] = '{1, 1, 0, 1, 1, 1, 1, 1};
    logic [7:0] dat[8] = '{1, 2, 0, 3, 4, 5, 6, 7};
    logic [2:0] exp[8] = '{3'b001, 3'b010, 3'b000, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};
    for (int i = 0; i < 8; i++) begin
      b_iv = vld[i]; b_id = dat[i]; b_is = 2'd3;
      tick();
      n_chk++; if (b_ov !== exp[i]) begin n_fail++; $display("FAIL rr_valid[%0d] got %b want %b", i, b_ov, exp[i]); end
      if (vld[i]) begin
        n_chk++; if (b_od !== dat[i]) begin n_fail++; $display("FAIL rr_data[%0d] got %h want %h", i, b_od, dat[i]); end
      end
    end
    b_iv = 0;
    tick();
  endtask
  task automatic test_drop();
    logic [1:0] exp[5] = '{1, 2, 3, 3, 3};
    c_iv = 1; c_is = 2'd3; c_id = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_chk++; if (c_ov !== 3'b0) begin n_fail++; $display("FAIL drop_valid[%0d] got %b want 000", i, c_ov); end
      n_chk++; if (c_err !== 1'b1) begin n_fail++; $display("FAIL drop_err[%0d] got %b want 1", i, c_err); end
      n_chk++; if (c_cnt !== exp[i]) begin n_fail++; $display("FAIL drop_cnt[%0d] got %0d want %0d", i, c_cnt, exp[i]); end
      n_chk++; if (c_ir !== 1'b1) begin n_fail++; $display("FAIL drop_ready[%0d] got %b want 1", i, c_ir); end
    end
    c_iv = 0;
    tick();
    n_chk++; if (c_err !== 1'b0 || c_cnt !== 2'd3) begin n_fail++; $display("FAIL drop_idle got err=%b cnt=%0d want 0/3", c_err, c_cnt); end
  endtask
  task automatic test_reset_midstream();
    b_or = 3'b000;
    b_iv = 1; b_id = 8'h55;
    tick();
    b_iv = 0;
    n_chk++; if (b_ov !== 3'b010 || b_od !== 8'h55) begin n_fail++; $display("FAIL mid_held got %b/%h want 010/55", b_ov, b_od); end
    rst_n = 0;
    tick();
    rst_n = 1;
    n_chk++; if (b_ov !== 3'b0 || b_od !== 8'h00) begin n_fail++; $display("FAIL mid_clear got %b/%h want 000/00", b_ov, b_od); end
    n_chk++; if (b_err !== 1'b0 || c_err !== 1'b0 || c_cnt !== 2'd0) begin n_fail++; $display("FAIL mid_err got berr=%b cerr=%b ccnt=%0d want 0/0/0", b_err, c_err, c_cnt); end
    b_or = 3'h7;
    b_iv = 1; b_id = 8'h66;
    tick();
    b_iv = 0;
    n_chk++; if (b_ov !== 3'b001 || b_od !== 8'h66) begin n_fail++; $display("FAIL mid_restart got %b/%h want 001/66", b_ov, b_od); end
  endtask
  initial begin
    test_reset();
    test_addressed_sweep();
    test_backpressure();
    test_round_robin();
    test_drop();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
